// File: rtl/cdc_handshake_tx_if.sv
// Handshake bundle for cdc_handshake_tx: local valid/ready source side
// plus the req/ack/data lines that cross into the remote clock domain.
interface cdc_handshake_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  xfer_req;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  xfer_ack_async;
  logic                  done;
  logic                  err;

  modport master (
    input  s_valid,
    input  s_data,
    input  xfer_ack_async,
    output s_ready,
    output xfer_req,
    output xfer_data,
    output done,
    output err
  );

  modport slave (
    output s_valid,
    output s_data,
    output xfer_ack_async,
    input  s_ready,
    input  xfer_req,
    input  xfer_data,
    input  done,
    input  err
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack clock-domain crossing.
// Optional ack timeout: define CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset,
  cdc_handshake_tx_if.master bus
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cdc_handshake_tx: bad parameters");
  end

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    SETTLE,
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [SYNC_STAGES-1:0]  sync_d;
  logic                    req_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    done_q;
  logic                    ack_s;
  logic                    accept;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.xfer_ack_async};
  assign ack_s  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // A stale ack seen in IDLE blocks new words until the remote side lets go
  assign bus.s_ready = (state_q == IDLE) && !ack_s;
  assign accept      = bus.s_valid && bus.s_ready;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        SETTLE: begin
          if (cnt_q != CW'(SYNC_STAGES)) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (!ack_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (accept) begin
            data_q  <= bus.s_data;
            req_q   <= 1'b1;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= DROP;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DROP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DROP: begin
          if (!ack_s) begin
            // A timed-out word never completed, so it gets no done pulse
            done_q  <= !err_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign bus.err = err_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        SETTLE: begin
          if (cnt_q != CW'(SYNC_STAGES)) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (!ack_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (accept) begin
            data_q  <= bus.s_data;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= DROP;
          end
        end
        DROP: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign bus.err = 1'b0;
`endif

  assign bus.xfer_req  = req_q;
  assign bus.xfer_data = data_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (SYNC_STAGES=3, TIMEOUT_CYCLES=16).
// Timeout vectors run only when CDC_TX_TIMEOUT_EN is defined.
module tb_cdc_handshake_tx;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   auto_ack = 1'b0;

  cdc_handshake_tx_if #(.DATA_WIDTH(8)) bus ();

  cdc_handshake_tx #(
    .DATA_WIDTH    (8),
    .SYNC_STAGES   (3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_ack) bus.xfer_ack_async = bus.xfer_req;
  endtask

  logic [7:0] words [4];
  int         t_acc [4];
  int         idx;
  int         dones;
  bit         acc;

  initial begin
    words = '{8'h01, 8'h02, 8'h03, 8'h04};
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.xfer_ack_async = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.s_ready), 0);
    check("rst_req", 32'(bus.xfer_req), 0);
    check("rst_data", 32'(bus.xfer_data), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);

    // settle: cnt 0..3 keeps s_ready low, IDLE after 4th edge
    reset = 1'b0;
    check("settle_c0", 32'(bus.s_ready), 0);
    repeat (3) tick();
    check("settle_c3", 32'(bus.s_ready), 0);
    tick();
    check("settle_rdy", 32'(bus.s_ready), 1);

    // single word 0xA5, ack 2 cycles after req
    bus.s_valid = 1'b1;
    bus.s_data = 8'hA5;
    tick();
    check("a5_req", 32'(bus.xfer_req), 1);
    check("a5_data", 32'(bus.xfer_data), 32'hA5);
    check("a5_busy", 32'(bus.s_ready), 0);
    bus.s_data = 8'hFF;
    repeat (2) tick();
    bus.xfer_ack_async = 1'b1;
    repeat (3) tick();
    check("a5_req_hold", 32'(bus.xfer_req), 1);
    tick();
    check("a5_req_fall", 32'(bus.xfer_req), 0);
    check("a5_data_req", 32'(bus.xfer_data), 32'hA5);
    bus.xfer_ack_async = 1'b0;
    repeat (3) tick();
    check("a5_no_done", 32'(bus.done), 0);
    check("a5_data_drop", 32'(bus.xfer_data), 32'hA5);
    bus.s_valid = 1'b0;
    tick();
    check("a5_done", 32'(bus.done), 1);
    check("a5_ready", 32'(bus.s_ready), 1);
    tick();
    check("a5_done_1cyc", 32'(bus.done), 0);
    check("a5_err", 32'(bus.err), 0);

    // back-to-back with zero-delay remote ack
    auto_ack = 1'b1;
    idx = 0;
    dones = 0;
    bus.s_valid = 1'b1;
    bus.s_data = words[0];
    for (int c = 0; c < 200 && dones < 4; c++) begin
      acc = bus.s_valid && bus.s_ready;
      tick();
      if (acc) begin
        check("b2b_data", 32'(bus.xfer_data), 32'(words[idx]));
        t_acc[idx] = cyc;
        idx++;
        if (idx < 4) bus.s_data = words[idx];
        else bus.s_valid = 1'b0;
      end
      if (bus.done) begin
        check("b2b_latency", 32'(cyc - t_acc[dones]), 8);
        dones++;
      end
    end
    check("b2b_dones", 32'(dones), 4);
    check("b2b_accepts", 32'(idx), 4);
    auto_ack = 1'b0;
    bus.s_valid = 1'b0;
    bus.xfer_ack_async = 1'b0;
    tick();

    // ack held high through reset
    reset = 1'b1;
    bus.xfer_ack_async = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    check("ackhi_ready", 32'(bus.s_ready), 0);
    check("ackhi_req", 32'(bus.xfer_req), 0);
    bus.xfer_ack_async = 1'b0;
    repeat (3) tick();
    check("ackhi_wait", 32'(bus.s_ready), 0);
    tick();
    check("ackhi_ready1", 32'(bus.s_ready), 1);
    check("ackhi_req0", 32'(bus.xfer_req), 0);

    // reset while in REQ
    bus.s_valid = 1'b1;
    bus.s_data = 8'h33;
    tick();
    bus.s_valid = 1'b0;
    check("mid_req", 32'(bus.xfer_req), 1);
    tick();
    #2 reset = 1'b1;
    #1;
    check("mid_req_async", 32'(bus.xfer_req), 0);
    check("mid_done", 32'(bus.done), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("mid_ready", 32'(bus.s_ready), 1);
    check("mid_no_done", 32'(bus.done), 0);
    auto_ack = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h5A;
    tick();
    bus.s_valid = 1'b0;
    check("mid_data", 32'(bus.xfer_data), 32'h5A);
    dones = 0;
    for (int c = 0; c < 20 && dones == 0; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("mid_restart_done", 32'(dones), 1);
    check("mid_data_end", 32'(bus.xfer_data), 32'h5A);
    auto_ack = 1'b0;
    bus.xfer_ack_async = 1'b0;

`ifdef CDC_TX_TIMEOUT_EN
    // ack never rises: req held 16 cycles, then err
    bus.s_valid = 1'b1;
    bus.s_data = 8'h77;
    tick();
    bus.s_valid = 1'b0;
    check("to_req", 32'(bus.xfer_req), 1);
    check("to_err0", 32'(bus.err), 0);
    repeat (15) tick();
    check("to_req_hold", 32'(bus.xfer_req), 1);
    tick();
    check("to_req_fall", 32'(bus.xfer_req), 0);
    check("to_err1", 32'(bus.err), 1);
    check("to_done_a", 32'(bus.done), 0);
    tick();
    check("to_done_b", 32'(bus.done), 0);
    check("to_ready", 32'(bus.s_ready), 1);
    check("to_err_sticky", 32'(bus.err), 1);
    bus.s_valid = 1'b1;
    bus.s_data = 8'h78;
    tick();
    bus.s_valid = 1'b0;
    check("to_err_clr", 32'(bus.err), 0);
    check("to_data", 32'(bus.xfer_data), 32'h78);
    auto_ack = 1'b1;
    dones = 0;
    for (int c = 0; c < 20 && dones == 0; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("to_next_done", 32'(dones), 1);
    auto_ack = 1'b0;
    bus.xfer_ack_async = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
